// File: rtl/stack8_ctrl_if.sv
// Handshake and status bundle between the 8-entry LIFO and its producer/consumer.
// The master side drives push/pop requests; the slave side is the stack itself.
interface stack8_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_req;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic [0:7]       occ;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_valid, pop_data, occ, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_valid, pop_data, occ, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack8_ctrl.sv
// 8-entry LIFO: thermometer-coded occupancy, data slots, popped-word register and
// one-cycle overflow/underflow pulses. Occupancy grows from occ[7] towards occ[0].
module stack8_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    stack8_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [0:7]       occ_q, occ_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty_s, full_s, push_ready_s;
    logic             push_acc_s, pop_acc_s, lone_push_s, lone_pop_s, replace_s;
    logic [2:0]       top_idx_s, wr_idx_s;

    function automatic logic [3:0] popcount8(input logic [0:7] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Accept decisions, all taken from the current registered state.
    always_comb begin
        empty_s      = (state_q == S_EMPTY);
        full_s       = (state_q == S_FULL);
        push_ready_s = !full_s | bus.pop_req;
        push_acc_s   = bus.push_valid & push_ready_s;
        pop_acc_s    = bus.pop_req & !empty_s;
        lone_push_s  = push_acc_s & !pop_acc_s;
        lone_pop_s   = pop_acc_s & !push_acc_s;
        replace_s    = push_acc_s & pop_acc_s;
        top_idx_s    = 3'(count_q - 4'd1);
        wr_idx_s     = count_q[2:0];
    end

    // Next occupancy code and its population count.
    always_comb begin
        occ_d = occ_q;
        if (lone_push_s) begin
            occ_d = {occ_q[1:7], 1'b1};
        end else if (lone_pop_s) begin
            occ_d = {1'b0, occ_q[0:6]};
        end else begin
            occ_d = occ_q;
        end
        count_d = popcount8(occ_d);
    end

    // Occupancy state machine; replace and idle hold the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (push_acc_s) state_d = S_PART;
                else            state_d = S_EMPTY;
            end
            S_PART: begin
                if (lone_pop_s && count_q == 4'd1)       state_d = S_EMPTY;
                else if (lone_push_s && count_q == 4'd7) state_d = S_FULL;
                else                                     state_d = S_PART;
            end
            S_FULL: begin
                if (lone_pop_s) state_d = S_PART;
                else            state_d = S_FULL;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Slot writes, popped-word capture and error pulses.
    always_comb begin
        slot_d = slot_q;
        if (lone_push_s) begin
            slot_d[wr_idx_s] = bus.push_data;
        end else if (replace_s) begin
            // Old top is captured into pop_data below before being overwritten.
            slot_d[top_idx_s] = bus.push_data;
        end else begin
            slot_d = slot_q;
        end
        if (pop_acc_s) pop_data_d = slot_q[top_idx_s];
        else           pop_data_d = pop_data_q;
        pop_valid_d = pop_acc_s;
        overflow_d  = bus.push_valid & full_s & !bus.pop_req;
        underflow_d = bus.pop_req & empty_s;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            occ_q       <= 8'b0000_0000;
            count_q     <= 4'd0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Data slots carry no reset; occupancy alone defines which are live.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign bus.push_ready = push_ready_s;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.pop_data   = pop_data_q;
    assign bus.occ        = occ_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty_s;
    assign bus.full       = full_s;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_stack8_ctrl.sv
// Bench for stack8_ctrl: directed scenarios then biased random traffic, all
// compared against a queue-based LIFO model.
module tb_stack8_ctrl;

    logic clk;
    logic reset;

    stack8_ctrl_if #(.WIDTH(8)) bus ();

    stack8_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_pop_data;
    logic       m_pop_valid;
    logic       m_ovf;
    logic       m_unf;
    logic       model_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic pv, input logic [7:0] pd, input logic pr);
        int   n;
        logic full_m, empty_m, ready_m;
        @(negedge clk);
        reset          = rst;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_req    = pr;
        #1;
        n       = q.size();
        full_m  = (n == 8);
        empty_m = (n == 0);
        ready_m = !full_m | pr;
        if (model_valid && !rst) check("push_ready", {31'd0, bus.push_ready}, {31'd0, ready_m});
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pop_valid = 1'b0;
            m_pop_data  = 8'h00;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_ovf       = pv & full_m & !pr;
            m_unf       = pr & empty_m;
            m_pop_valid = pr & !empty_m;
            if (m_pop_valid) m_pop_data = q.pop_back();
            if (pv & ready_m) q.push_back(pd);
        end
        #1;
        if (model_valid) begin
            n = q.size();
            check("occ",       {24'd0, bus.occ},       (32'd1 << n) - 32'd1);
            check("count",     {28'd0, bus.count},     n);
            check("empty",     {31'd0, bus.empty},     {31'd0, (n == 0)});
            check("full",      {31'd0, bus.full},      {31'd0, (n == 8)});
            check("pop_valid", {31'd0, bus.pop_valid}, {31'd0, m_pop_valid});
            check("pop_data",  {24'd0, bus.pop_data},  {24'd0, m_pop_data});
            check("overflow",  {31'd0, bus.overflow},  {31'd0, m_ovf});
            check("underflow", {31'd0, bus.underflow}, {31'd0, m_unf});
        end
    endtask

    initial begin
        int push_pct [4];
        int pop_pct  [4];
        push_pct = '{80, 50, 20, 50};
        pop_pct  = '{20, 50, 80, 50};
        clk            = 1'b0;
        reset          = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = 8'h00;
        bus.pop_req    = 1'b0;
        model_valid    = 1'b0;
        m_pop_data     = 8'h00;
        m_pop_valid    = 1'b0;
        m_ovf          = 1'b0;
        m_unf          = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Push three, pop three, then pop on empty.
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill, overflow, pop, refill, replace at full, pop.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h09, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h08, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset during a pop at count 3, then push/pop.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Push and pop together on empty, then pop.
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic, biased per phase to visit full and empty often.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 150; c++) begin
                step(($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 99) < push_pct[ph]),
                     8'($urandom),
                     ($urandom_range(0, 99) < pop_pct[ph]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack8_ctrl.md
Name: stack8_ctrl

Overview:
- 8-entry LIFO controller and datapath that owns the stack occupancy register and the data slots.
- Occupancy is held as a right-aligned thermometer code occ[0:7]:
  - occ[7] is the bottom slot, occ[0] the top-most slot.
  - 00000000 = empty, 11111111 = full.
- Each cycle the block computes the next occupancy from the current code and the push/pop decision, registers it, and moves data accordingly.
- Sits between the producer/consumer handshakes and the downstream users of occupancy status.

Parameters:
- WIDTH, 8, data word width in bits.
- Depth is fixed at 8 by the thermometer encoding and is not a parameter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- push_valid  input  1  producer offers push_data this cycle.
- push_data  input  WIDTH  word to push.
- push_ready  output  1  push accepted this cycle if push_valid is also high.
- pop_req  input  1  consumer requests a pop this cycle.
- pop_valid  output  1  pop_data holds a popped word (one-cycle pulse).
- pop_data  output  WIDTH  popped word.
- occ  output  [0:7]  thermometer occupancy register.
- count  output  4  number of stored words, 0..8.
- empty  output  1  occ == 00000000.
- full  output  1  occ == 11111111.
- overflow  output  1  one-cycle pulse on a rejected push.
- underflow  output  1  one-cycle pulse on a rejected pop.

Behaviour:
- Reset (sampled on clk while reset=1):
  - occ=00000000, count=0, FSM=EMPTY, empty=1, full=0.
  - pop_valid=0, pop_data=0, overflow=0, underflow=0.
  - Data slots need not be cleared.
  - Reset mid-operation discards all contents and any pending pop output; reset has priority over every other input.
- Accept rules (combinational from the current state):
  - push_ready = !full | pop_req.
  - push_acc = push_valid & push_ready.
  - pop_acc = pop_req & !empty.
- Next occupancy:
  - push only: occ_next[i] = occ[i+1] for i=0..6, occ_next[7]=1 (shift in a 1 at the bottom end).
  - pop only: occ_next[0]=0, occ_next[i] = occ[i-1] for i=1..7.
  - Both accepted, or neither: occ unchanged.
- count:
  - count is the population count of occ, registered in the same cycle as occ.
  - count must always equal the number of ones in occ.
- Data storage:
  - slot[j], j=0..7. The current top is slot[count-1].
  - push only: slot[count] <= push_data.
  - pop only: pop_data <= slot[count-1], pop_valid=1 on the next cycle.
  - push and pop both accepted (replace): pop_data <= old top, and the same top slot is overwritten with push_data. Occupancy is unchanged.
  - Push and pop together on an empty stack: push accepted, pop rejected (underflow pulses), pop_valid=0. There is no bypass of push_data to pop_data.
  - Push and pop together on a full stack: treated as replace; push_ready=1, no overflow.
- Latency:
  - Popped data appears one cycle after the pop is accepted.
  - A pushed word is poppable starting the cycle after it is pushed.
  - pop_data holds its last value when pop_valid=0.
- Errors (both pulses registered, asserted one cycle after the offending request):
  - overflow: push_valid & full & !pop_req.
  - underflow: pop_req & empty.
  - The rejected operation has no effect on occ or the slots.
- FSM:
  - States: EMPTY (count 0), PART (count 1..7), FULL (count 8).
  - EMPTY -> PART on push_acc.
  - PART -> EMPTY on a lone pop at count 1.
  - PART -> FULL on a lone push at count 7.
  - FULL -> PART on a lone pop.
  - Replace, or idle, keeps the current state.
  - empty and full are decoded from FSM state and must match the occ decode.
- Invariant: occ is always a valid right-aligned thermometer code. Verification asserts this every cycle.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles -> occ sequence 00000001, 00000011, 00000111; count=3; empty=0.
2. From test 1, pop three times -> pop_data 0x33, 0x22, 0x11, each with pop_valid one cycle after its pop_req; final occ=00000000, empty=1; a fourth pop gives an underflow pulse with occ unchanged.
3. Push 8 words 0x01..0x08 -> occ=11111111, full=1, push_ready=0; a 9th push_valid without pop gives an overflow pulse, and a subsequent pop returns 0x08.
4. At full, assert push 0xAA and pop together -> pop_data=0x08, occ stays 11111111; the next pop returns 0xAA.
5. With count=3, assert reset for 1 cycle during a pop -> pop_valid=0, occ=00000000, count=0; the next push 0x5A followed by a pop returns 0x5A.
6. On an empty stack, assert push 0x77 and pop together -> underflow pulse, pop_valid=0, occ=00000001; the next pop returns 0x77.
